wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register writeback arbiter between ALU results and a 2-entry load-result queue
module wb_arbiter #(
    parameter int XLEN    = 64,
    parameter int QDEPTH  = 2,
    parameter int AGE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid_i,
    input  logic            alu_wen_i,
    input  logic [4:0]      alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            w_ena_o,
    output logic [4:0]      w_addr_o,
    output logic [XLEN-1:0] w_data_o,
    output logic            stall_req_o,
    output logic [31:0]     pending_o
);

    localparam logic [1:0] QFULL   = 2'(QDEPTH);
    localparam logic [2:0] AGE_LIM = 3'(AGE_MAX);

    logic [4:0]      q_rd   [0:1];
    logic [XLEN-1:0] q_data [0:1];
    logic [1:0]      q_valid;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic [2:0]      age;

    logic            push;
    logic            sel_pop;
    logic            sel_alu;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign head_rd   = q_rd[rd_ptr];
    assign head_data = q_data[rd_ptr];

    // Queue status and writeback source selection; a waiting head that has aged out wins over the ALU
    always_comb begin
        mem_ready_o = (count < QFULL);
        stall_req_o = (count == QFULL) || ((count != 2'd0) && (age == AGE_LIM));
        push        = mem_valid_i && mem_ready_o;
        sel_pop     = 1'b0;
        sel_alu     = 1'b0;
        if (stall_req_o) begin
            sel_pop = 1'b1;
        end else if (alu_valid_i && alu_wen_i) begin
            sel_alu = 1'b1;
        end else if (count != 2'd0) begin
            sel_pop = 1'b1;
        end
    end

    // Scoreboard of destination registers still waiting in the queue; x0 never reported
    always_comb begin
        pending_o = '0;
        for (int i = 0; i < 2; i++) begin
            if (q_valid[i]) begin
                pending_o[q_rd[i]] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

    // Queue storage, pointers, count and head age
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
            age     <= '0;
        end else begin
            if (sel_pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= ~rd_ptr;
            end
            if (push) begin
                q_rd[wr_ptr]    <= mem_rd_i;
                q_data[wr_ptr]  <= mem_data_i;
                q_valid[wr_ptr] <= 1'b1;
                wr_ptr          <= ~wr_ptr;
            end
            case ({push, sel_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (sel_pop || (count == 2'd0)) begin
                age <= '0;
            end else if (age != AGE_LIM) begin
                age <= age + 3'd1;
            end
        end
    end

    // Registered regfile write port; writes to x0 are swallowed and idle outputs are zeroed
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ena_o  <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
        end else if (sel_pop && (head_rd != 5'd0)) begin
            w_ena_o  <= 1'b1;
            w_addr_o <= head_rd;
            w_data_o <= head_data;
        end else if (sel_alu && (alu_rd_i != 5'd0)) begin
            w_ena_o  <= 1'b1;
            w_addr_o <= alu_rd_i;
            w_data_o <= alu_data_i;
        end else begin
            w_ena_o  <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i, alu_wen_i;
    logic [4:0]  alu_rd_i;
    logic [63:0] alu_data_i;
    logic        mem_valid_i, mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic [63:0] mem_data_i;
    logic        w_ena_o;
    logic [4:0]  w_addr_o;
    logic [63:0] w_data_o;
    logic        stall_req_o;
    logic [31:0] pending_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [31:0] cyc;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    wb_arbiter #(.XLEN(64), .QDEPTH(2), .AGE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_wen_i(alu_wen_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .w_ena_o(w_ena_o), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
        .stall_req_o(stall_req_o), .pending_o(pending_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic wen, input logic [4:0] rd, input logic [63:0] d);
        alu_valid_i = v; alu_wen_i = wen; alu_rd_i = rd; alu_data_i = d;
    endtask

    task automatic mem(input logic v, input logic [4:0] rd, input logic [63:0] d);
        mem_valid_i = v; mem_rd_i = rd; mem_data_i = d;
    endtask

    // expected write becomes visible one edge after the current cycle's selection
    task automatic expect_w(input logic [4:0] rd, input logic [63:0] d);
        exp_q.push_back('{rd: rd, data: d, cyc: cyc + 1});
    endtask

    // Every observed write must match the oldest expected write, including its cycle
    always @(negedge clk) begin
        if (w_ena_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {59'd0, w_addr_o}, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("w_addr", {59'd0, w_addr_o}, {59'd0, e.rd});
                check("w_data", w_data_o, e.data);
                check("w_cycle", {32'd0, cyc}, {32'd0, e.cyc});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        alu(0, 0, 0, 0);
        mem(0, 0, 0);
        step(); step();
        check("rst_w_ena", {63'd0, w_ena_o}, 64'd0);
        check("rst_w_addr", {59'd0, w_addr_o}, 64'd0);
        check("rst_w_data", w_data_o, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready_o}, 64'd1);
        check("rst_stall", {63'd0, stall_req_o}, 64'd0);
        check("rst_pending", {32'd0, pending_o}, 64'd0);
        rst = 1'b0;
        step();

        // ALU only
        alu(1, 1, 5, 64'h1234);
        expect_w(5, 64'h1234);
        step();
        alu(0, 0, 0, 0);
        check("alu_w_ena", {63'd0, w_ena_o}, 64'd1);
        check("alu_w_addr", {59'd0, w_addr_o}, 64'd5);
        check("alu_w_data", w_data_o, 64'h1234);
        step();
        check("idle_w_ena", {63'd0, w_ena_o}, 64'd0);
        check("idle_w_data", w_data_o, 64'd0);

        // Fill queue with continuous ALU writes
        mem(1, 3, 64'h33); alu(1, 1, 1, 64'hA0); expect_w(1, 64'hA0); step();
        mem(1, 4, 64'h44); alu(1, 1, 1, 64'hA1); expect_w(1, 64'hA1); step();
        mem(0, 0, 0);
        check("full_mem_ready", {63'd0, mem_ready_o}, 64'd0);
        check("full_stall", {63'd0, stall_req_o}, 64'd1);
        check("full_pending", {32'd0, pending_o}, 64'h18);
        alu(1, 1, 1, 64'hA2); expect_w(3, 64'h33); step();
        check("after_pop_stall", {63'd0, stall_req_o}, 64'd0);
        check("after_pop_pending", {32'd0, pending_o}, 64'h10);
        for (int i = 3; i < 6; i++) begin
            alu(1, 1, 1, 64'hA0 + 64'(i)); expect_w(1, 64'hA0 + 64'(i)); step();
        end
        check("aged_rd4_stall", {63'd0, stall_req_o}, 64'd1);
        alu(1, 1, 1, 64'hA6); expect_w(4, 64'h44); step();
        alu(0, 0, 0, 0); step(); step();
        check("fill_drained_pending", {32'd0, pending_o}, 64'd0);

        // Age limit: rd=7 waits behind continuous ALU writes
        for (int i = 0; i < 8; i++) begin
            check($sformatf("age_stall_%0d", i), {63'd0, stall_req_o}, (i == 4) ? 64'd1 : 64'd0);
            if (i == 0) mem(1, 7, 64'h77); else mem(0, 0, 0);
            alu(1, 1, 2, 64'hB0 + 64'(i));
            if (i == 4) expect_w(7, 64'h77); else expect_w(2, 64'hB0 + 64'(i));
            step();
        end
        alu(0, 0, 0, 0); step();

        // x0 handling
        mem(1, 0, 64'hFF); step();
        mem(0, 0, 0);
        check("x0_pending_a", {32'd0, pending_o}, 64'd0);
        alu(1, 1, 0, 64'h5); step();
        alu(0, 0, 0, 0);
        check("x0_pending_b", {32'd0, pending_o}, 64'd0);
        step(); step();
        check("x0_pending_c", {32'd0, pending_o}, 64'd0);
        check("x0_drained_ready", {63'd0, mem_ready_o}, 64'd1);
        check("x0_drained_stall", {63'd0, stall_req_o}, 64'd0);

        // Simultaneous push and pop at count=1; drain with ALU valid but not writing
        mem(1, 9, 64'h99); step();
        mem(1, 10, 64'hAA); expect_w(9, 64'h99); step();
        mem(0, 0, 0);
        check("simul_mem_ready", {63'd0, mem_ready_o}, 64'd1);
        check("simul_stall", {63'd0, stall_req_o}, 64'd0);
        check("simul_pending", {32'd0, pending_o}, 64'h400);
        alu(1, 0, 6, 64'hDEAD); expect_w(10, 64'hAA); step();
        alu(0, 0, 0, 0); step();
        check("simul_drained_pending", {32'd0, pending_o}, 64'd0);

        // Reset with a full queue, pushes offered during reset are dropped
        mem(1, 11, 64'hB1); alu(1, 1, 2, 64'hC0); expect_w(2, 64'hC0); step();
        mem(1, 12, 64'hB2); alu(1, 1, 2, 64'hC1); expect_w(2, 64'hC1); step();
        check("prerst_mem_ready", {63'd0, mem_ready_o}, 64'd0);
        check("prerst_pending", {32'd0, pending_o}, 64'h1800);
        rst = 1'b1; alu(0, 0, 0, 0); mem(1, 13, 64'hB3);
        step(); step();
        rst = 1'b0; mem(0, 0, 0);
        check("postrst_w_ena", {63'd0, w_ena_o}, 64'd0);
        check("postrst_mem_ready", {63'd0, mem_ready_o}, 64'd1);
        check("postrst_stall", {63'd0, stall_req_o}, 64'd0);
        check("postrst_pending", {32'd0, pending_o}, 64'd0);
        for (int i = 0; i < 4; i++) step();
        check("postrst_pending_late", {32'd0, pending_o}, 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
